// File: rtl/l2_rsp_out_packetizer.sv
// l2_rsp_out_packetizer: serializes L2 coherence responses into header + masked data NoC flits
module l2_rsp_out_packetizer #(
    parameter int WORD_BITS      = 64,
    parameter int WORDS_PER_LINE = 2,
    parameter int FLIT_BITS      = 64,
    parameter int MSG_BITS       = 5,
    parameter int REQ_ID_BITS    = 4,
    parameter int DEST_BITS      = 4,
    parameter int LINE_ADDR_BITS = 28
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                l2_rsp_out_valid,
    output logic                                l2_rsp_out_ready,
    input  logic [MSG_BITS-1:0]                 rsp_coh_msg,
    input  logic [REQ_ID_BITS-1:0]              rsp_req_id,
    input  logic [DEST_BITS-1:0]                rsp_to_req,
    input  logic [LINE_ADDR_BITS-1:0]           rsp_addr,
    input  logic [WORD_BITS*WORDS_PER_LINE-1:0] rsp_line,
    input  logic [WORDS_PER_LINE-1:0]           rsp_word_mask,
    input  logic                                rsp_has_data,
    output logic                                noc_valid,
    input  logic                                noc_ready,
    output logic [FLIT_BITS-1:0]                noc_data,
    output logic                                noc_head,
    output logic                                noc_tail,
    output logic                                busy
);
    localparam int HDR_BITS = MSG_BITS + WORDS_PER_LINE + REQ_ID_BITS + DEST_BITS + LINE_ADDR_BITS;
    localparam int WI = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;

    state_t                              state, state_d;
    logic [WI-1:0]                       widx, widx_d, first_idx, next_idx;
    logic                                has_next, data_needed, tail, fire, accept;
    logic [MSG_BITS-1:0]                 coh_msg;
    logic [REQ_ID_BITS-1:0]              req_id;
    logic [DEST_BITS-1:0]                to_req;
    logic [LINE_ADDR_BITS-1:0]           addr;
    logic [WORD_BITS*WORDS_PER_LINE-1:0] line;
    logic [WORDS_PER_LINE-1:0]           mask;
    logic                                has_data;
    logic [WORD_BITS-1:0]                word;
    logic [FLIT_BITS-1:0]                hdr, dat;

    // mask scan: lowest set bit, next set bit above widx, and the current word
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        word      = '0;
        for (int i = WORDS_PER_LINE - 1; i >= 0; i--) begin
            if (mask[i]) first_idx = WI'(i);
            if (mask[i] && WI'(i) > widx) begin
                next_idx = WI'(i);
                has_next = 1'b1;
            end
            if (WI'(i) == widx) word = line[i*WORD_BITS +: WORD_BITS];
        end
    end

    // flit payload formatting, upper bits zero
    always_comb begin
        hdr = '0;
        hdr[HDR_BITS-1:0] = {addr, to_req, req_id, mask, coh_msg};
        dat = '0;
        dat[WORD_BITS-1:0] = word;
    end

    assign data_needed      = has_data & (|mask);
    assign tail             = (state == HEAD) ? !data_needed : !has_next;
    assign noc_valid        = !rst && state != IDLE;
    assign noc_head         = noc_valid && state == HEAD;
    assign noc_tail         = noc_valid & tail;
    assign noc_data         = !noc_valid ? '0 : (state == HEAD) ? hdr : dat;
    assign busy             = noc_valid;
    assign fire             = noc_valid & noc_ready;
    assign l2_rsp_out_ready = !rst && (state == IDLE || (fire && tail));
    assign accept           = l2_rsp_out_valid & l2_rsp_out_ready;

    // next state: advance on flit handshake, refill on accept (tail cycle or idle)
    always_comb begin
        state_d = state;
        widx_d  = widx;
        if (fire) begin
            state_d = tail ? IDLE : DATA;
            widx_d  = tail ? '0 : (state == HEAD) ? first_idx : next_idx;
        end
        if (accept) begin
            state_d = HEAD;
            widx_d  = '0;
        end
    end

    // state and message capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            widx     <= '0;
            coh_msg  <= '0;
            req_id   <= '0;
            to_req   <= '0;
            addr     <= '0;
            line     <= '0;
            mask     <= '0;
            has_data <= 1'b0;
        end else begin
            state <= state_d;
            widx  <= widx_d;
            if (accept) begin
                coh_msg  <= rsp_coh_msg;
                req_id   <= rsp_req_id;
                to_req   <= rsp_to_req;
                addr     <= rsp_addr;
                line     <= rsp_line;
                mask     <= rsp_word_mask;
                has_data <= rsp_has_data;
            end
        end
    end
endmodule
